jt51_sample_fmt: RTL and testbench



---
 rtl/jt51_pkg.sv | 34 +++
 rtl/jt51_sample_dly.sv | 35 +++
 rtl/jt51_sample_fmt.sv | 61 ++++++
 tb/tb_jt51_sample_fmt.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/jt51_pkg.sv
// Shared widths and the exponent selector used by the JT51 output formatting stage.
package jt51_pkg;

    localparam int MAN_W = 10;
    localparam int EXP_W = 3;
    localparam int LIN_W = 16;

    // Exponent from the top seven bits of a linear sample: 7 when bit 14 already
    // differs from the sign, falling to 1 when all seven bits match the sign.
    function automatic logic [EXP_W-1:0] exp_sel(input logic [6:0] lead);
        logic [EXP_W-1:0] e;
        e = 3'd1;
        if (lead[6] != lead[5]) begin
            e = 3'd7;
        end else if (lead[5] != lead[4]) begin
            e = 3'd6;
        end else if (lead[4] != lead[3]) begin
            e = 3'd5;
        end else if (lead[3] != lead[2]) begin
            e = 3'd4;
        end else if (lead[2] != lead[1]) begin
            e = 3'd3;
        end else if (lead[1] != lead[0]) begin
            e = 3'd2;
        end
        return e;
    endfunction

    // Number of low linear bits discarded for a given exponent.
    function automatic logic [EXP_W-1:0] exp_shift(input logic [EXP_W-1:0] e);
        return (e == 3'd0) ? 3'd0 : e - 3'd1;
    endfunction

endpackage

// File: rtl/jt51_sample_dly.sv
// Clock-enabled sample delay line: STAGES registers that advance only while cen is high.
module jt51_sample_dly #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] tap [0:STAGES];

    assign tap[0] = din;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg <= '0;
                end else if (cen) begin
                    stage_reg <= tap[gi];
                end
            end

            assign tap[gi+1] = stage_reg;
        end
    endgenerate

    assign dout = tap[STAGES];

endmodule

// File: rtl/jt51_sample_fmt.sv
// Output sample formatter: delays the linear sample, converts it to the DAC
// float (mantissa/exponent) and expands the float back to the reproduced linear value.
module jt51_sample_fmt
    import jt51_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] drop,
    output logic [MAN_W-1:0] man,
    output logic [EXP_W-1:0] exp,
    output logic [LIN_W-1:0] lin
);

    jt51_sample_dly #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (din),
        .dout (drop)
    );

    // Lin-to-exp: keep the ten bits just below the redundant sign bits, truncating the rest.
    always_comb begin
        exp = exp_sel(drop[LIN_W-1:LIN_W-7]);
        case (exp)
            3'd7:    man = drop[15:6];
            3'd6:    man = drop[14:5];
            3'd5:    man = drop[13:4];
            3'd4:    man = drop[12:3];
            3'd3:    man = drop[11:2];
            3'd2:    man = drop[10:1];
            default: man = drop[9:0];
        endcase
    end

    // Exp-to-lin: sign-extend the mantissa and shift it back into place.
    always_comb begin
        case (exp_shift(exp))
            3'd6:    lin = {man, 6'b0};
            3'd5:    lin = {man[9], man, 5'b0};
            3'd4:    lin = {{2{man[9]}}, man, 4'b0};
            3'd3:    lin = {{3{man[9]}}, man, 3'b0};
            3'd2:    lin = {{4{man[9]}}, man, 2'b0};
            3'd1:    lin = {{5{man[9]}}, man, 1'b0};
            default: lin = {{6{man[9]}}, man};
        endcase
        // exp=0 is never generated here but keeps its defined half-scale expansion.
        if (exp == 3'd0) begin
            lin = {{7{man[9]}}, man[9:1]};
        end
    end

endmodule

// File: tb/tb_jt51_sample_fmt.sv
// Self-checking bench for jt51_sample_fmt: directed cases plus random stream vs a queue/arithmetic model.
module tb_jt51_sample_fmt;

    localparam int STAGES = 8;

    logic        clk;
    logic        rst;
    logic        cen;
    logic [15:0] din;
    logic [15:0] drop;
    logic [9:0]  man;
    logic [2:0]  exp;
    logic [15:0] lin;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] q [$];

    jt51_sample_fmt #(
        .WIDTH  (16),
        .STAGES (STAGES)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .din  (din),
        .drop (drop),
        .man  (man),
        .exp  (exp),
        .lin  (lin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Float conversion from first principles: smallest exponent whose scaled value fits 10 signed bits.
    task automatic ref_conv(input logic [15:0] v, output logic [2:0] e,
                            output logic [9:0] m, output logic [15:0] l);
        int sv;
        int s;
        sv = int'($signed(v));
        e = 3'd7;
        m = '0;
        l = '0;
        for (int k = 1; k <= 7; k++) begin
            s = sv >>> (k - 1);
            if (s >= -512 && s <= 511) begin
                e = 3'(k);
                m = s[9:0];
                l = 16'(s * (1 << (k - 1)));
                break;
            end
        end
    endtask

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < STAGES; i++) q.push_back(16'h0000);
    endtask

    task automatic check_model(input string tag);
        logic [2:0]  e;
        logic [9:0]  m;
        logic [15:0] l;
        ref_conv(q[0], e, m, l);
        check({tag, ".drop"}, 32'(drop), 32'(q[0]));
        check({tag, ".exp"},  32'(exp),  32'(e));
        check({tag, ".man"},  32'(man),  32'(m));
        check({tag, ".lin"},  32'(lin),  32'(l));
    endtask

    // Called just after a negedge: apply inputs, take one posedge, compare at next negedge.
    task automatic cycle(input logic c, input logic [15:0] d, input string tag);
        cen = c;
        din = d;
        @(posedge clk);
        if (c) begin
            q.push_back(d);
            void'(q.pop_front());
        end
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic directed(input logic [15:0] v, input logic [2:0] e,
                            input logic [9:0] m, input logic [15:0] l, input string tag);
        cycle(1'b1, v, tag);
        for (int i = 1; i < STAGES; i++) cycle(1'b1, 16'h0000, tag);
        check({tag, ".k_drop"}, 32'(drop), 32'(v));
        check({tag, ".k_exp"},  32'(exp),  32'(e));
        check({tag, ".k_man"},  32'(man),  32'(m));
        check({tag, ".k_lin"},  32'(lin),  32'(l));
    endtask

    initial begin
        logic signed [15:0] r;
        rst = 1'b1;
        cen = 1'b0;
        din = 16'h0000;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst.drop", 32'(drop), 32'h0);
        check("rst.exp",  32'(exp),  32'h1);
        check("rst.man",  32'(man),  32'h0);
        check("rst.lin",  32'(lin),  32'h0);
        rst = 1'b0;

        // Test 1: constant 0x0123, drop stays 0 until the 8th enabled edge.
        for (int i = 0; i < STAGES; i++) begin
            cycle(1'b1, 16'h0123, "t1");
            if (i < STAGES - 1) check("t1.zero", 32'(drop), 32'h0);
        end
        check("t1.drop", 32'(drop), 32'h0123);
        check("t1.exp",  32'(exp),  32'h1);
        check("t1.man",  32'(man),  32'h123);
        check("t1.lin",  32'(lin),  32'h0123);

        directed(16'h1234, 3'd5, 10'h123, 16'h1230, "t2");
        directed(16'h7FFF, 3'd7, 10'h1FF, 16'h7FC0, "t3a");
        directed(16'h8000, 3'd7, 10'h200, 16'h8000, "t3b");
        directed(16'hFFFF, 3'd1, 10'h3FF, 16'hFFFF, "t4a");
        directed(16'hFF00, 3'd1, 10'h300, 16'hFF00, "t4b");

        // Test 5: counting stream with cen toggling every clock.
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1, 16'(k), "t5");
            cycle(1'b0, 16'hDEAD, "t5h");
        end

        // Test 6: asynchronous reset mid-stream, checked before any clock edge.
        for (int k = 0; k < 5; k++) cycle(1'b1, 16'h4000 + 16'(k), "t6pre");
        #1 rst = 1'b1;
        #1;
        check("t6.drop", 32'(drop), 32'h0);
        check("t6.exp",  32'(exp),  32'h1);
        check("t6.man",  32'(man),  32'h0);
        check("t6.lin",  32'(lin),  32'h0);
        model_clear();
        cen = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < STAGES + 4; k++) cycle(1'b1, 16'h2000 + 16'(k), "t6post");

        // Random stream spanning all exponents and random cen gaps.
        for (int i = 0; i < 600; i++) begin
            r = 16'($urandom);
            r = r >>> $urandom_range(0, 15);
            cycle(1'($urandom_range(0, 3) != 0), r, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
